// File: rtl/sign_ctrl_mc.sv
// Multi-channel sign-block reset sequencer: each channel releases its sign block
// from reset for a programmable number of sign_en strobes, then locks until re-armed.
module sign_ctrl_mc #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 8,
    parameter bit AUTO_REARM = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  sign_en,
    input  logic [N_CH-1:0]  rearm,
    input  logic [CNT_W-1:0] win_len,
    output logic [N_CH-1:0]  sign_reset,
    output logic [N_CH-1:0]  sign_done,
    output logic             any_active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Per-channel status bundle; kept as one struct so checkers can bind to it.
    typedef struct packed {
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             rst_out;
        logic             done_out;
    } chan_t;

    chan_t chan_q [N_CH];
    chan_t chan_d [N_CH];

    logic [CNT_W-1:0] win_eff;
    logic [N_CH-1:0]  active_vec;

    // A zero window length behaves as a single-strobe window.
    assign win_eff = (win_len == '0) ? CNT_W'(1) : win_len;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                chan_q[i].state    <= IDLE;
                chan_q[i].cnt      <= '0;
                chan_q[i].rst_out  <= 1'b1;
                chan_q[i].done_out <= 1'b0;
            end else begin
                chan_q[i] <= chan_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            chan_d[i] = chan_q[i];
            case (chan_q[i].state)
                IDLE: begin
                    if (sign_en[i]) begin
                        chan_d[i].state = ACTIVE;
                        chan_d[i].cnt   = win_eff;
                    end
                end
                ACTIVE: begin
                    // rearm aborts the window and wins over a coincident strobe.
                    if (rearm[i]) begin
                        chan_d[i].state = IDLE;
                    end else if (sign_en[i]) begin
                        if (chan_q[i].cnt > CNT_W'(1)) begin
                            chan_d[i].cnt = chan_q[i].cnt - CNT_W'(1);
                        end else begin
                            chan_d[i].state = DONE;
                        end
                    end
                end
                DONE: begin
                    if (AUTO_REARM || rearm[i]) begin
                        chan_d[i].state = IDLE;
                    end
                end
                default: begin
                    chan_d[i].state = IDLE;
                end
            endcase
            // Outputs are registered copies decoded from the next state.
            chan_d[i].rst_out  = (chan_d[i].state != ACTIVE);
            chan_d[i].done_out = (chan_d[i].state == DONE);
        end
    end

    always_comb begin
        active_vec = '0;
        sign_reset = '0;
        sign_done  = '0;
        for (int i = 0; i < N_CH; i++) begin
            active_vec[i] = (chan_q[i].state == ACTIVE);
            sign_reset[i] = chan_q[i].rst_out;
            sign_done[i]  = chan_q[i].done_out;
        end
    end

    assign any_active = |active_vec;

endmodule

// File: tb/tb_sign_ctrl_mc.sv
// Bench for sign_ctrl_mc: a manual-rearm and an auto-rearm instance share stimulus
// and are checked every cycle against a strobe-counting model, plus literal checks.
module tb_sign_ctrl_mc;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_CH-1:0]  sign_en = '0;
    logic [N_CH-1:0]  rearm = '0;
    logic [CNT_W-1:0] win_len = 8'd1;

    logic [N_CH-1:0]  sign_reset_a, sign_done_a, sign_reset_b, sign_done_b;
    logic             any_active_a, any_active_b;

    int checks = 0;
    int failures = 0;

    // clock / reset block
    always #5 clk = ~clk;

    sign_ctrl_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .AUTO_REARM(1'b0)) dut_a (
        .clk(clk), .rst(rst), .sign_en(sign_en), .rearm(rearm), .win_len(win_len),
        .sign_reset(sign_reset_a), .sign_done(sign_done_a), .any_active(any_active_a)
    );

    sign_ctrl_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .AUTO_REARM(1'b1)) dut_b (
        .clk(clk), .rst(rst), .sign_en(sign_en), .rearm(rearm), .win_len(win_len),
        .sign_reset(sign_reset_b), .sign_done(sign_done_b), .any_active(any_active_b)
    );

    // Model: strobes counted since arming (0 = not armed) and the latched window L.
    // Released while 1 <= strobes <= L; locked (done) once strobes > L.
    int m_cnt [2][N_CH];
    int m_len [2][N_CH];
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            model_valid <= 1'b1;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < N_CH; i++) begin
                    m_cnt[k][i] <= 0;
                    m_len[k][i] <= 1;
                end
        end else begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < N_CH; i++) begin
                    if (m_cnt[k][i] > m_len[k][i]) begin
                        if (k == 1 || rearm[i]) m_cnt[k][i] <= 0;
                    end else if (m_cnt[k][i] >= 1) begin
                        if (rearm[i]) m_cnt[k][i] <= 0;
                        else if (sign_en[i]) m_cnt[k][i] <= m_cnt[k][i] + 1;
                    end else if (sign_en[i]) begin
                        m_len[k][i] <= (win_len == 0) ? 1 : int'(win_len);
                        m_cnt[k][i] <= 1;
                    end
                end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // scoreboard compare process: one expected vector per output per cycle
    always @(negedge clk) begin
        if (model_valid) begin
            logic [N_CH-1:0] er [2];
            logic [N_CH-1:0] ed [2];
            logic            ea [2];
            for (int k = 0; k < 2; k++) begin
                ea[k] = 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    er[k][i] = !(m_cnt[k][i] >= 1 && m_cnt[k][i] <= m_len[k][i]);
                    ed[k][i] = (m_cnt[k][i] > m_len[k][i]);
                    if (!er[k][i]) ea[k] = 1'b1;
                end
            end
            check("model_sign_reset_a", 32'(sign_reset_a), 32'(er[0]));
            check("model_sign_done_a",  32'(sign_done_a),  32'(ed[0]));
            check("model_any_active_a", 32'(any_active_a), 32'(ea[0]));
            check("model_sign_reset_b", 32'(sign_reset_b), 32'(er[1]));
            check("model_sign_done_b",  32'(sign_done_b),  32'(ed[1]));
            check("model_any_active_b", 32'(any_active_b), 32'(ea[1]));
        end
    end

    // driver: apply one cycle of inputs, return at the following negedge
    task automatic tick(input logic [N_CH-1:0] en, input logic [N_CH-1:0] ra,
                        input logic [CNT_W-1:0] wl, input logic r);
        sign_en = en;
        rearm   = ra;
        win_len = wl;
        rst     = r;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // reset for 2 cycles, then quiet inputs
        tick(4'b0000, 4'b0000, 8'd1, 1'b1);
        tick(4'b0000, 4'b0000, 8'd1, 1'b1);
        repeat (3) tick(4'b0000, 4'b0000, 8'd1, 1'b0);
        check("rst_sign_reset", 32'(sign_reset_a), 32'h0000_000f);
        check("rst_sign_done",  32'(sign_done_a),  32'h0);
        check("rst_any_active", 32'(any_active_a), 32'h0);

        // single-shot on ch0, win_len=1
        tick(4'b0001, 4'b0000, 8'd1, 1'b0);
        check("ss_released", 32'(sign_reset_a), 32'h0000_000e);
        check("ss_active",   32'(any_active_a), 32'h1);
        repeat (5) tick(4'b0000, 4'b0000, 8'd1, 1'b0);
        tick(4'b0001, 4'b0000, 8'd1, 1'b0);
        check("ss_reasserted", 32'(sign_reset_a), 32'h0000_000f);
        check("ss_done",       32'(sign_done_a),  32'h0000_0001);
        check("ss_auto_done",  32'(sign_done_b),  32'h0000_0001);
        tick(4'b0001, 4'b0000, 8'd1, 1'b0);
        check("ss_locked_done", 32'(sign_done_a), 32'h0000_0001);
        check("ss_auto_idle",   32'(sign_done_b), 32'h0);
        tick(4'b0000, 4'b0001, 8'd1, 1'b0);
        check("ss_rearm_done", 32'(sign_done_a), 32'h0);

        // window of 3 strobes on ch1 at cycles 0,4,5,9; win_len jumps to 10 at cycle 2
        for (int c = 0; c <= 10; c++) begin
            tick((c == 0 || c == 4 || c == 5 || c == 9) ? 4'b0010 : 4'b0000, 4'b0000,
                 (c >= 2) ? 8'd10 : 8'd3, 1'b0);
            if (c == 5) check("win_still_released", 32'(sign_reset_a[1]), 32'h0);
            if (c == 9) begin
                check("win_reasserted", 32'(sign_reset_a[1]), 32'h1);
                check("win_done",       32'(sign_done_a[1]),  32'h1);
            end
        end

        // abort: ch2 at cnt=2, strobe and rearm together
        tick(4'b0100, 4'b0000, 8'd3, 1'b0);
        tick(4'b0100, 4'b0000, 8'd3, 1'b0);
        tick(4'b0100, 4'b0100, 8'd3, 1'b0);
        check("abort_reset", 32'(sign_reset_a[2]), 32'h1);
        check("abort_done",  32'(sign_done_a[2]),  32'h0);
        tick(4'b0100, 4'b0000, 8'd3, 1'b0);
        check("abort_restart", 32'(sign_reset_a[2]), 32'h0);
        tick(4'b0000, 4'b1111, 8'd3, 1'b0);

        // win_len=0 on ch3: two strobes reach DONE
        tick(4'b1000, 4'b0000, 8'd0, 1'b0);
        tick(4'b1000, 4'b0000, 8'd0, 1'b0);
        check("wl0_auto_done", 32'(sign_done_b[3]), 32'h1);
        tick(4'b0000, 4'b0000, 8'd0, 1'b0);
        check("wl0_auto_done_1cyc", 32'(sign_done_b[3]), 32'h0);
        check("wl0_auto_idle_rst",  32'(sign_reset_b[3]), 32'h1);
        tick(4'b1000, 4'b0000, 8'd0, 1'b0);
        check("wl0_auto_rerelease", 32'(sign_reset_b[3]), 32'h0);
        check("wl0_manual_locked",  32'(sign_done_a[3]),  32'h1);
        tick(4'b0000, 4'b1111, 8'd0, 1'b0);

        // mid-window reset with every channel released
        tick(4'b1111, 4'b0000, 8'd5, 1'b0);
        check("mid_all_active", 32'(sign_reset_a), 32'h0);
        tick(4'b0000, 4'b0000, 8'd5, 1'b1);
        check("mid_rst_reset",  32'(sign_reset_a), 32'h0000_000f);
        check("mid_rst_any",    32'(any_active_a), 32'h0);
        check("mid_rst_reset_b", 32'(sign_reset_b), 32'h0000_000f);

        // randomized traffic, checked by the per-cycle model only
        for (int c = 0; c < 200; c++) begin
            tick(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                 8'($urandom_range(0, 4)),
                 ($urandom_range(0, 60) == 0));
        end
        tick(4'b0000, 4'b0000, 8'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sign_ctrl_mc.md
# sign_ctrl_mc

Multi-channel, parametrised sign-block reset sequencer. Each channel holds its downstream sign block in reset until an enable strobe arrives. It then releases the reset for a programmable number of enable strobes and re-asserts it. A channel stays locked in that state until it is re-armed, or until it re-arms itself automatically. With `win_len`=1 a channel reproduces the existing single-shot release/re-assert sequence. The block sits between the sequencing logic that issues `sign_en` strobes and up to `N_CH` independent sign datapaths.

## Interface
Parameters:
- `N_CH`, 4, number of independent channels (≥1)
- `CNT_W`, 8, width of the window-length counter
- `AUTO_REARM`, 0, 1 = a channel leaves DONE to IDLE automatically after one cycle; 0 = a channel waits in DONE for `rearm`

Ports:
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `sign_en`  in  N_CH  per-channel advance strobe; each cycle high counts as one strobe
- `rearm`  in  N_CH  per-channel return to IDLE (abort when the channel is ACTIVE)
- `win_len`  in  CNT_W  release window, in strobes; shared by all channels; 0 is treated as 1
- `sign_reset`  out  N_CH  registered reset to the sign block (1 = held in reset)
- `sign_done`  out  N_CH  registered; 1 while the channel is in DONE
- `any_active`  out  1  OR over channels of (state == ACTIVE); decoded from the state registers

## Operation
- Each channel has its own state register (IDLE/ACTIVE/DONE), a CNT_W-bit counter `cnt`, and registered `sign_reset` and `sign_done`.
- On `rst`, every channel goes to IDLE, with `cnt`=0, `sign_reset`=1 and `sign_done`=0. `rst` overrides all other inputs.
- Priority within a channel: `rst` > `rearm` > `sign_en`.
- IDLE: `sign_reset`=1 and `sign_done`=0.
  - `sign_en`=1 → ACTIVE. `cnt` loads max(`win_len`,1). `sign_reset` goes to 0.
  - `rearm` in IDLE is ignored.
- ACTIVE: `sign_reset`=0.
  - `rearm`=1 → IDLE. `sign_reset` goes to 1. `sign_done` stays 0.
  - `sign_en`=1 with `cnt`>1 → `cnt` decrements.
  - `sign_en`=1 with `cnt`==1 → DONE. `sign_reset` goes to 1 and `sign_done` goes to 1.
- DONE: `sign_reset`=1 and `sign_done`=1. `sign_en` is ignored.
  - `AUTO_REARM`=0: `rearm`=1 → IDLE and `sign_done` goes to 0.
  - `AUTO_REARM`=1: the channel moves to IDLE unconditionally on the next edge.
- `win_len` is sampled only on the IDLE→ACTIVE edge. Changes while a channel is ACTIVE have no effect on that window.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- Window semantics: the reset is released after strobe 1 and re-asserted after strobe L+1, where L = max(`win_len`,1).

## Timing
- All outputs except `any_active` are registered.
- `sign_reset` and `sign_done` change in the cycle after the edge that samples the causing input. The latency is 1 clock.
- `any_active` is decoded from the state registers, so it changes on the same edge as `sign_reset`.
- A `sign_en` held high for k cycles counts as k strobes. Example: in IDLE with L=2, three consecutive high cycles give IDLE→ACTIVE→ACTIVE→DONE.
- Minimum time in ACTIVE is L cycles; there is no maximum.
- With `AUTO_REARM`=1, DONE lasts exactly 1 cycle. The earliest the channel can re-enter ACTIVE is 2 edges after entering DONE.
- Asserting `rst` on any cycle, including mid-window, forces the reset values on the next edge.
- The counter never wraps. It is loaded with ≥1 and leaves ACTIVE when it reaches 1.

## Test plan
- Reset: hold `rst` for 2 cycles, then release it with all inputs at 0 → `sign_reset`=4'b1111, `sign_done`=0, `any_active`=0. These values hold indefinitely.
- Single-shot (N_CH=4, `AUTO_REARM`=0, `win_len`=1): pulse `sign_en`[0] for 1 cycle, wait 5 cycles, pulse it again → `sign_reset`[0] is 0 from edge 1 until the second pulse, then 1. `sign_done`[0] goes to 1. Further pulses do not change either output. Other channels are unaffected.
- Window length: `win_len`=3; issue strobes on ch1 at cycles 0, 4, 5, 9 → `sign_reset`[1] is 0 from cycle 1 through the edge after cycle 9, then 1. Changing `win_len` to 10 at cycle 2 has no effect on this window.
- Abort and priority: ch2 ACTIVE with `cnt`=2; assert `sign_en`[2] and `rearm`[2] in the same cycle → next cycle the channel is in IDLE with `sign_reset`[2]=1 and `sign_done`[2]=0. A subsequent `sign_en` restarts the window.
- `win_len`=0 plus `AUTO_REARM`=1: give ch3 two strobes → ch3 reaches DONE. `sign_done`[3] is high for exactly 1 cycle, then the channel returns to IDLE. A third strobe releases the reset again.
- Mid-window reset: all 4 channels ACTIVE; assert `rst` for 1 cycle → all channels in IDLE, `sign_reset`=4'b1111, `any_active`=0 on the next edge.
